sync_fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. It adds arbitrary (non-power-of-2) depth, a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between single-clock producer/consumer datapaths and is the default buffering primitive for new blocks.

---
 rtl/sync_fifo_flex.sv | 179 +++++++++++++++++
 tb/tb_sync_fifo_flex.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through reads,
// occupancy/threshold flags, sticky error flags and flush. Define SYNC_FIFO_WATERMARK_EN to add max_count.
module sync_fifo_flex #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
`ifdef SYNC_FIFO_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   max_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty,
  // both judged on the registered flags at the start of the cycle; clr suppresses both.
  always_comb begin
    wr_acc      = wr_en && !full_q && !clr;
    rd_acc      = rd_en && !empty_q && !clr;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wr_en && full_q) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty_q) begin
        underflow_d = 1'b1;
      end
    end

    full_d         = (count_d == CNT_MAX);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_LVL);
    almost_empty_d = (count_d <= AE_LVL);
  end

  // In fall-through mode the output register tracks the next head word; when that
  // head is the slot being written this cycle, the incoming data is forwarded.
  always_comb begin
    rd_data_d = rd_data_q;
    if (FWFT != 0) begin
      if (!clr) begin
        if (count_d == '0) begin
          rd_data_d = '0;
        end else if (wr_acc && (rd_ptr_d == wr_ptr_q)) begin
          rd_data_d = wr_data;
        end else begin
          rd_data_d = mem_q[rd_ptr_d];
        end
      end
    end else if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CW-1:0] max_count_q, max_count_d;

  always_comb begin
    max_count_d = max_count_q;
    if (clr) begin
      max_count_d = '0;
    end else if (count_d > max_count_q) begin
      max_count_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_count_q <= '0;
    end else begin
      max_count_q <= max_count_d;
    end
  end

  assign max_count = max_count_q;
`endif

  assign rd_data      = rd_data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: standard and fall-through instances driven in lockstep,
// checked against a queue-based reference model with a scoreboard for read data.
module tb_sync_fifo_flex;

  localparam int DEPTH = 10;
  localparam int WIDTH = 8;
  localparam int AF    = 8;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst, clr, wr_en, rd_en;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             full0, empty0, af0, ae0, ovf0, unf0;
  logic             full1, empty1, af1, ae1, ovf1, unf1;
  logic [CW-1:0]    count0, count1;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CW-1:0]    max0, max1;
`endif

  sync_fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
`ifdef SYNC_FIFO_WATERMARK_EN
    , .max_count(max0)
`endif
  );

  sync_fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
`ifdef SYNC_FIFO_WATERMARK_EN
    , .max_count(max1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf, m_unf;
  int               m_max;
  logic [WIDTH-1:0] m_fw;
  logic             rd_pend;
  logic             mon_en;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver: apply one cycle of inputs, then advance the model across the edge
  task automatic step(input logic rs, input logic c, input logic w, input logic [WIDTH-1:0] d,
                      input logic r);
    int n;
    rst = rs; clr = c; wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    rd_pend = 1'b0;
    if (rs) begin
      m_q.delete(); exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_max = 0; m_fw = '0;
    end else if (c) begin
      m_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_max = 0;
    end else begin
      n = m_q.size();
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0) m_unf = 1'b1;
      if (r && n != 0) begin
        exp_q.push_back(m_q.pop_front());
        rd_pend = 1'b1;
      end
      if (w && n != DEPTH) m_q.push_back(d);
      if (m_q.size() > m_max) m_max = m_q.size();
      m_fw = (m_q.size() != 0) ? m_q[0] : '0;
    end
    #1;
  endtask

  // monitor: compares status every cycle and read data when a read was accepted
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count0), 32'(m_q.size()));
      chk("empty", 32'(empty0), 32'(m_q.size() == 0));
      chk("full", 32'(full0), 32'(m_q.size() == DEPTH));
      chk("almost_full", 32'(af0), 32'(m_q.size() >= AF));
      chk("almost_empty", 32'(ae0), 32'(m_q.size() <= AE));
      chk("overflow", 32'(ovf0), 32'(m_ovf));
      chk("underflow", 32'(unf0), 32'(m_unf));
      chk("f_count", 32'(count1), 32'(m_q.size()));
      chk("f_empty", 32'(empty1), 32'(m_q.size() == 0));
      chk("f_full", 32'(full1), 32'(m_q.size() == DEPTH));
      chk("f_almost_full", 32'(af1), 32'(m_q.size() >= AF));
      chk("f_almost_empty", 32'(ae1), 32'(m_q.size() <= AE));
      chk("f_overflow", 32'(ovf1), 32'(m_ovf));
      chk("f_underflow", 32'(unf1), 32'(m_unf));
      chk("f_rd_data", 32'(rd_data1), 32'(m_fw));
`ifdef SYNC_FIFO_WATERMARK_EN
      chk("max_count", 32'(max0), 32'(m_max));
      chk("f_max_count", 32'(max1), 32'(m_max));
`endif
      if (rd_pend) begin
        if (exp_q.size() == 0) chk("scoreboard_underrun", 32'(exp_q.size()), 32'd1);
        else chk("rd_data", 32'(rd_data0), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    mon_en = 1'b0; rd_pend = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_max = 0; m_fw = '0;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    mon_en = 1'b1;
    chk("reset_rd_data", 32'(rd_data0), 32'h0);
    chk("reset_f_rd_data", 32'(rd_data1), 32'h0);
    chk("reset_empty", 32'(empty0), 32'd1);
    chk("reset_almost_empty", 32'(ae0), 32'd1);

    // fill and overflow
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 8'(i), 0);
      if (i == 2) chk("ae_at_2", 32'(ae0), 32'd1);
      if (i == 3) chk("ae_at_3", 32'(ae0), 32'd0);
      if (i == 7) chk("af_at_7", 32'(af0), 32'd0);
      if (i == 8) chk("af_at_8", 32'(af0), 32'd1);
    end
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_count", 32'(count0), 32'd10);
    step(0, 0, 1, 8'hFF, 0);
    chk("ovf_set", 32'(ovf0), 32'd1);
    chk("ovf_count", 32'(count0), 32'd10);

    // drain and underflow
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, 8'h00, 1);
      chk("drain_order", 32'(rd_data0), 32'(i));
    end
    chk("drain_empty", 32'(empty0), 32'd1);
    step(0, 0, 0, 8'h00, 1);
    chk("unf_set", 32'(unf0), 32'd1);
    chk("unf_rd_hold", 32'(rd_data0), 32'h0A);

    // wrap across the last slot
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 1);
    chk("wrap_count", 32'(count0), 32'd0);

    // simultaneous access
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 1);
    chk("simul_count5", 32'(count0), 32'd5);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    step(0, 0, 1, 8'hEE, 1);
    chk("simul_full_count", 32'(count0), 32'd9);
    chk("simul_full_ovf", 32'(ovf0), 32'd1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 8'h00, 1);
    step(0, 0, 1, 8'hDD, 1);
    chk("simul_empty_count", 32'(count0), 32'd1);
    chk("simul_empty_unf", 32'(unf0), 32'd1);

    // flush with a same-cycle write
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
    chk("pre_flush_count", 32'(count0), 32'd6);
    step(0, 1, 1, 8'hAB, 0);
    chk("flush_count", 32'(count0), 32'd0);
    chk("flush_empty", 32'(empty0), 32'd1);
    chk("flush_ovf", 32'(ovf0), 32'd0);
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("flush_max", 32'(max0), 32'd0);
`endif
    step(0, 0, 0, 8'h00, 0);
    chk("flush_write_ignored", 32'(count0), 32'd0);

    // fall-through sequence
    step(0, 0, 1, 8'h55, 0);
    chk("fwft_first", 32'(rd_data1), 32'h55);
    chk("fwft_not_empty", 32'(empty1), 32'd0);
    step(0, 0, 1, 8'h66, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("fwft_advance", 32'(rd_data1), 32'h66);
    step(0, 0, 0, 8'h00, 1);
    chk("fwft_drained_empty", 32'(empty1), 32'd1);
    chk("fwft_drained_data", 32'(rd_data1), 32'h0);

    // randomized traffic: write-heavy, read-heavy, then balanced with rare flush
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int wp;
        int rp;
        wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
        rp = 100 - wp;
        step(0, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
             8'($urandom),
             ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0);
      end
    end

    step(0, 0, 0, 8'h00, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
